// File: rtl/rdback_serializer.sv
// rtl/rdback_serializer.sv - round-robin readback FIFO to OUT_WIDTH beat serializer.
// Define RDBACK_WORD_CNT_EN to build the per-channel delivered-word counters.
module rdback_serializer #(
  parameter int DQ_WIDTH  = 256,
  parameter int OUT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 fifo_empty_pc0,
  output logic                 fifo_rd_en_pc0,
  input  logic [DQ_WIDTH-1:0]  fifo_dout_pc0,
  input  logic                 fifo_empty_pc1,
  output logic                 fifo_rd_en_pc1,
  input  logic [DQ_WIDTH-1:0]  fifo_dout_pc1,
  output logic [OUT_WIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 m_tid,
  output logic                 busy,
  output logic [31:0]          word_cnt_pc0,
  output logic [31:0]          word_cnt_pc1
);

  localparam int BEATS = DQ_WIDTH / OUT_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [DQ_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                tid_q, tid_d;
  logic                sel_q, sel_d;
  // Channel that wins the next tie; flips to the other channel after each pop.
  logic                prio_q, prio_d;

  logic any_pc0, any_pc1, pick_pc1, pop, beat_xfer, last_xfer;

  assign any_pc0  = !fifo_empty_pc0;
  assign any_pc1  = !fifo_empty_pc1;
  assign pick_pc1 = any_pc1 && (!any_pc0 || prio_q);
  assign pop      = (state_q == ST_IDLE) && (any_pc0 || any_pc1);

  // Gated by rstn so a non-empty FIFO is never popped while reset is held.
  assign fifo_rd_en_pc0 = rstn && pop && !pick_pc1;
  assign fifo_rd_en_pc1 = rstn && pop && pick_pc1;

  assign m_tvalid  = (state_q == ST_SEND);
  assign m_tdata   = shift_q[OUT_WIDTH-1:0];
  assign m_tlast   = m_tvalid && (beat_q == LAST_BEAT);
  assign m_tid     = tid_q;
  assign busy      = (state_q != ST_IDLE);
  assign beat_xfer = m_tvalid && m_tready;
  assign last_xfer = beat_xfer && (beat_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    tid_d   = tid_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          sel_d   = pick_pc1;
          prio_d  = !pick_pc1;
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d = sel_q ? fifo_dout_pc1 : fifo_dout_pc0;
        tid_d   = sel_q;
        beat_d  = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (beat_xfer) begin
          shift_d = shift_q >> OUT_WIDTH;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      beat_q  <= '0;
      tid_q   <= 1'b0;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      beat_q  <= beat_d;
      tid_q   <= tid_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
    end
  end

`ifdef RDBACK_WORD_CNT_EN
  logic [31:0] cnt_pc0_q, cnt_pc0_d;
  logic [31:0] cnt_pc1_q, cnt_pc1_d;

  always_comb begin
    cnt_pc0_d = cnt_pc0_q;
    cnt_pc1_d = cnt_pc1_q;
    if (last_xfer) begin
      if (tid_q) cnt_pc1_d = cnt_pc1_q + 32'd1;
      else       cnt_pc0_d = cnt_pc0_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_pc0_q <= '0;
      cnt_pc1_q <= '0;
    end else begin
      cnt_pc0_q <= cnt_pc0_d;
      cnt_pc1_q <= cnt_pc1_d;
    end
  end

  assign word_cnt_pc0 = cnt_pc0_q;
  assign word_cnt_pc1 = cnt_pc1_q;
`else
  logic unused_last_xfer;
  assign unused_last_xfer = last_xfer;
  assign word_cnt_pc0     = 32'd0;
  assign word_cnt_pc1     = 32'd0;
`endif

endmodule

// File: tb/tb_rdback_serializer.sv
// tb/tb_rdback_serializer.sv - randomized bench for rdback_serializer against a word-level model.
module tb_rdback_serializer;

  localparam int DQW   = 256;
  localparam int OW    = 64;
  localparam int NB    = DQW / OW;
  localparam int DEPTH = 128;
`ifdef RDBACK_WORD_CNT_EN
  localparam bit WC_EN = 1'b1;
`else
  localparam bit WC_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic           m_tready = 1'b1;
  logic           rd0, rd1, empty0, empty1;
  logic [DQW-1:0] dout0 = '0, dout1 = '0;
  logic [OW-1:0]  m_tdata;
  logic           m_tvalid, m_tlast, m_tid, busy;
  logic [31:0]    wc0, wc1;

  always #5 clk = ~clk;

  rdback_serializer #(.DQ_WIDTH(DQW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rstn(rstn),
    .fifo_empty_pc0(empty0), .fifo_rd_en_pc0(rd0), .fifo_dout_pc0(dout0),
    .fifo_empty_pc1(empty1), .fifo_rd_en_pc1(rd1), .fifo_dout_pc1(dout1),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tid(m_tid), .busy(busy), .word_cnt_pc0(wc0), .word_cnt_pc1(wc1)
  );

  // Readback FIFOs: written by the stimulus process, popped only by the rd_en model below.
  logic [DQW-1:0] mem0 [DEPTH];
  logic [DQW-1:0] mem1 [DEPTH];
  int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);

  always @(posedge clk) begin
    if (rd0 && rp0 < DEPTH) begin dout0 <= mem0[rp0]; rp0 <= rp0 + 1; end
    if (rd1 && rp1 < DEPTH) begin dout1 <= mem1[rp1]; rp1 <= rp1 + 1; end
  end

  // Monitor: records accepted beats and protocol observations on the falling edge.
  logic [OW-1:0] cap_d [$];
  logic          cap_t [$];
  logic          cap_l [$];
  int  viol = 0, nrd0 = 0, nrd1 = 0, seen_valid = 0, seen_busy = 0, hold_seen = 0, hold_err = 0;
  logic            stall_prev = 1'b0;
  logic [OW+2:0]   prev_v = '0;

  always @(negedge clk) begin
    if (rstn) begin
      if (rd0 && rd1) viol <= viol + 1;
      else if ((rd0 && empty0) || (rd1 && empty1)) viol <= viol + 1;
      if (rd0) nrd0 <= nrd0 + 1;
      if (rd1) nrd1 <= nrd1 + 1;
      if (m_tvalid) seen_valid <= seen_valid + 1;
      if (busy) seen_busy <= seen_busy + 1;
      if (stall_prev) begin
        hold_seen <= hold_seen + 1;
        if ({m_tvalid, m_tdata, m_tid, m_tlast} !== prev_v) hold_err <= hold_err + 1;
      end
      if (m_tvalid && m_tready) begin
        cap_d.push_back(m_tdata);
        cap_t.push_back(m_tid);
        cap_l.push_back(m_tlast);
      end
      stall_prev <= m_tvalid && !m_tready;
      prev_v     <= {m_tvalid, m_tdata, m_tid, m_tlast};
    end else begin
      stall_prev <= 1'b0;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: pending words per channel, tie preference, delivered counts.
  logic [DQW-1:0] m0 [$];
  logic [DQW-1:0] m1 [$];
  logic [OW-1:0]  exp_d [$];
  logic           exp_t [$];
  logic           exp_l [$];
  int  pref = 0, cnt0 = 0, cnt1 = 0;

  function automatic logic [DQW-1:0] rword();
    logic [DQW-1:0] r;
    for (int i = 0; i < DQW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic add_word(input int ch, input logic [DQW-1:0] w);
    if (ch == 0) begin mem0[wp0] = w; wp0++; m0.push_back(w); end
    else         begin mem1[wp1] = w; wp1++; m1.push_back(w); end
  endtask

  task automatic model_drain();
    int c;
    logic [DQW-1:0] w;
    exp_d.delete(); exp_t.delete(); exp_l.delete();
    while (m0.size() + m1.size() > 0) begin
      if (m0.size() > 0 && m1.size() > 0) c = pref;
      else c = (m0.size() > 0) ? 0 : 1;
      w = (c == 0) ? m0.pop_front() : m1.pop_front();
      pref = 1 - c;
      if (c == 0) cnt0++; else cnt1++;
      for (int b = 0; b < NB; b++) begin
        exp_d.push_back(w[b*OW +: OW]);
        exp_t.push_back(c[0]);
        exp_l.push_back(b == NB - 1);
      end
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_wc0"}, wc0, WC_EN ? cnt0 : 0);
    check({tag, "_wc1"}, wc1, WC_EN ? cnt1 : 0);
  endtask

  // mode 0: ready always high, 1: random ready, 2: 5-cycle stall while beat 1 is presented.
  task automatic run_scn(input string tag, input int mode);
    int base, nexp, b0, b1, n0, n1, h0, e0;
    bit stalled;
    base = cap_d.size(); b0 = nrd0; b1 = nrd1; h0 = hold_seen; e0 = hold_err;
    n0 = m0.size(); n1 = m1.size();
    model_drain();
    nexp = exp_d.size();
    stalled = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (cap_d.size() - base >= nexp) break;
      if (mode == 1) m_tready = ($urandom_range(0, 3) != 0);
      else m_tready = 1'b1;
      if (mode == 2 && !stalled && m_tvalid && cap_d.size() - base == 1) begin
        m_tready = 1'b0;
        repeat (5) @(posedge clk);
        #1 m_tready = 1'b1;
        stalled = 1'b1;
      end
    end
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_nbeats"}, cap_d.size() - base, nexp);
    for (int i = 0; i < nexp && base + i < cap_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), cap_d[base+i], exp_d[i]);
      check($sformatf("%s_tid%0d", tag, i), cap_t[base+i], exp_t[i]);
      check($sformatf("%s_last%0d", tag, i), cap_l[base+i], exp_l[i]);
    end
    check({tag, "_rd0"}, nrd0 - b0, n0);
    check({tag, "_rd1"}, nrd1 - b1, n1);
    check({tag, "_busy_end"}, busy, 1'b0);
    check_counters(tag);
    if (mode == 2) begin
      check({tag, "_hold_cycles"}, hold_seen - h0, 5);
      check({tag, "_hold_err"}, hold_err - e0, 0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rstn = 1'b0;
    pref = 0; cnt0 = 0; cnt1 = 0;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
  endtask

  initial begin
    int base, b0, b1, v0;
    logic [DQW-1:0] w;

    // Asynchronous reset before any clock edge, with a word already waiting in pc0.
    #2 rstn = 1'b0;
    #1;
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tdata", m_tdata, '0);
    check("rst_tlast", m_tlast, 1'b0);
    check("rst_tid", m_tid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check_counters("rst");
    w = {64'd3, 64'd2, 64'd1, 64'd0};
    add_word(0, w);
    #1;
    check("rst_rd0_held", rd0, 1'b0);
    check("rst_rd1_held", rd1, 1'b0);
    #22 rstn = 1'b1;

    run_scn("single", 0);
    add_word(0, rword());
    run_scn("stall", 2);

    // Reset while beat 2 of a word is on the bus.
    add_word(0, rword());
    base = cap_d.size();
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (cap_d.size() - base >= 2) break;
    end
    check("midrst_tvalid_pre", m_tvalid, 1'b1);
    rstn = 1'b0;
    m0.delete(); pref = 0; cnt0 = 0; cnt1 = 0;
    #1;
    check("midrst_tvalid", m_tvalid, 1'b0);
    check("midrst_tdata", m_tdata, '0);
    check("midrst_busy", busy, 1'b0);
    check_counters("midrst");
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    base = cap_d.size(); b0 = nrd0; b1 = nrd1; v0 = seen_valid;
    repeat (30) @(posedge clk);
    #1;
    check("midrst_no_beats", cap_d.size() - base, 0);
    check("midrst_no_valid", seen_valid - v0, 0);
    check("midrst_no_rd", (nrd0 - b0) + (nrd1 - b1), 0);

    for (int i = 0; i < 2; i++) begin add_word(0, rword()); add_word(1, rword()); end
    run_scn("both2", 0);

    base = seen_busy; b0 = nrd0; b1 = nrd1; v0 = seen_valid;
    repeat (100) @(posedge clk);
    #1;
    check("idle_rd", (nrd0 - b0) + (nrd1 - b1), 0);
    check("idle_valid", seen_valid - v0, 0);
    check("idle_busy", seen_busy - base, 0);

    for (int r = 0; r < 6; r++) begin
      int k0, k1;
      k0 = $urandom_range(0, 4);
      k1 = $urandom_range(0, 4);
      for (int i = 0; i < k0; i++) add_word(0, rword());
      for (int i = 0; i < k1; i++) add_word(1, rword());
      run_scn($sformatf("rnd%0d", r), 1);
    end

    do_reset();
    for (int i = 0; i < 3; i++) add_word(1, rword());
    run_scn("pc1x3", 1);

    check("no_bad_rd_en", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rdback_serializer.md
RDBACK_SERIALIZER -- requirements
Module: rdback_serializer

Interface
REQ-001 SHALL have parameter DQ_WIDTH, default 256, width of one readback FIFO word.
REQ-002 SHALL have parameter OUT_WIDTH, default 64, width of one output beat; DQ_WIDTH SHALL be an integer multiple of OUT_WIDTH.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fifo_empty_pc0  input  1  pseudo-channel 0 readback FIFO empty.
REQ-006 SHALL have port fifo_rd_en_pc0  output  1  pop request to pseudo-channel 0 FIFO.
REQ-007 SHALL have port fifo_dout_pc0  input  DQ_WIDTH  pseudo-channel 0 FIFO data, valid the cycle after fifo_rd_en_pc0.
REQ-008 SHALL have port fifo_empty_pc1  input  1  pseudo-channel 1 readback FIFO empty.
REQ-009 SHALL have port fifo_rd_en_pc1  output  1  pop request to pseudo-channel 1 FIFO.
REQ-010 SHALL have port fifo_dout_pc1  input  DQ_WIDTH  pseudo-channel 1 FIFO data, valid the cycle after fifo_rd_en_pc1.
REQ-011 SHALL have port m_tdata  output  OUT_WIDTH  output beat data.
REQ-012 SHALL have port m_tvalid  output  1  output beat valid.
REQ-013 SHALL have port m_tready  input  1  downstream accepts beat.
REQ-014 SHALL have port m_tlast  output  1  last beat of one FIFO word.
REQ-015 SHALL have port m_tid  output  1  source pseudo-channel of current word (0 or 1).
REQ-016 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-017 SHALL have ports word_cnt_pc0, word_cnt_pc1  output  32  words delivered per pseudo-channel (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, POP, LOAD, SEND.
REQ-019 IDLE: if any FIFO non-empty, SHALL pick channel, pulse that channel's rd_en for exactly one cycle, go to POP; else stay.
REQ-020 Arbitration SHALL be round-robin: when both non-empty, pick the channel not served last; after reset, pc0 wins first tie.
REQ-021 POP: SHALL wait one cycle for FIFO read latency, go to LOAD; rd_en SHALL be low.
REQ-022 LOAD: SHALL capture selected fifo_dout into shift register, latch m_tid, clear beat counter, go to SEND.
REQ-023 SEND: m_tvalid SHALL be high; m_tdata SHALL be shift register bits [OUT_WIDTH-1:0], least-significant slice first.
REQ-024 Beat SHALL transfer only on m_tvalid and m_tready both high; on transfer, shift right by OUT_WIDTH and increment beat counter.
REQ-025 m_tdata, m_tid, m_tlast SHALL stay stable while m_tvalid high and m_tready low.
REQ-026 m_tlast SHALL be high only on beat DQ_WIDTH/OUT_WIDTH-1 (beat 3 at defaults).
REQ-027 On last-beat transfer SHALL go to IDLE; total word throughput ≤ one word per (3 + DQ_WIDTH/OUT_WIDTH) cycles.
REQ-028 SHALL never assert both rd_en outputs in the same cycle, and never assert rd_en to an empty FIFO.
REQ-029 m_tready high outside SEND SHALL have no effect.

Reset
REQ-030 On rstn low SHALL asynchronously force: FSM IDLE, fifo_rd_en_pc0/pc1 0, m_tvalid 0, m_tlast 0, m_tid 0, m_tdata 0, busy 0, counters 0, round-robin pointer to pc0.
REQ-031 Reset mid-SEND SHALL discard the partially sent word; no beat after deassertion until a new pop.

Configuration
REQ-032 Macro RDBACK_WORD_CNT_EN defined: word_cnt_pcN SHALL increment by 1 on each last-beat transfer of channel N, wrapping 0xFFFFFFFF to 0.
REQ-033 Macro RDBACK_WORD_CNT_EN undefined: word_cnt_pc0/pc1 SHALL be constant 0 and no counter registers SHALL be synthesized.

Verification
REQ-034 pc0 holds one word 0x...0003_0002_0001_0000 (64-bit slices 0..3), m_tready=1 -> one rd_en_pc0 pulse, 4 beats 0,1,2,3, m_tlast on beat 3, m_tid=0.
REQ-035 Both FIFOs hold 2 words each, m_tready=1 -> word order pc0,pc1,pc0,pc1; 16 beats; m_tid toggles per word.
REQ-036 m_tready low for 5 cycles during beat 1 -> beat 1 data held stable, no extra rd_en, beats resume 2,3.
REQ-037 Both FIFOs empty for 100 cycles -> rd_en never asserted, m_tvalid 0, busy 0.
REQ-038 rstn pulsed low during beat 2 -> m_tvalid 0 immediately; after release with FIFOs empty, no beats emitted.
REQ-039 RDBACK_WORD_CNT_EN defined, 3 pc1 words delivered -> word_cnt_pc1=3, word_cnt_pc0=0; undefined -> both 0.
